multi_click_detector: RTL and testbench
=======================================

# multi_click_detector

Groups the single-cycle press pulses produced by the debounce + one-shot front end into click sequences and reports, once per sequence, how many clicks occurred (single, double, … up to a saturation limit). It sits directly downstream of the debounced one-shot button path. It gives FSM-driven designs one event per user gesture instead of one per press.

## Interface
- WINDOW_CYCLES, 12_500_000 — maximum idle gap, in clk cycles, between clicks of one sequence (250 ms at 50 MHz); must be ≥ 2
- MAX_CLICKS, 3 — saturation count; reaching it ends the sequence immediately; must be ≥ 2
- HOLDOFF_CYCLES, 0 — cycles after each report during which input pulses are ignored; 0 disables the holdoff
- clk  input  1  system clock; single clock domain
- rst  input  1  reset, synchronous, active-high
- click_pulse  input  1  click event, normally a one-cycle pulse; every cycle it is high counts as one click
- click_valid  output  1  one-cycle strobe: sequence finished, click_count valid
- click_count  output  CW = $clog2(MAX_CLICKS+1)  number of clicks in the finished sequence, 1..MAX_CLICKS
- busy  output  1  high while a sequence is open or holdoff is running

## Operation
- FSM states: IDLE, WAIT, HOLDOFF. Internal registers: `count` (CW bits) and `timer` (wide enough for max(WINDOW_CYCLES, HOLDOFF_CYCLES)).
- IDLE, click_pulse=1 → `count`=1, `timer`=0, go to WAIT.
- WAIT, click_pulse=1, and `count`+1 < MAX_CLICKS → `count`++, `timer`=0, stay in WAIT.
- WAIT, click_pulse=1, and `count`+1 == MAX_CLICKS → report MAX_CLICKS, then enter HOLDOFF (or IDLE if HOLDOFF_CYCLES=0).
- WAIT, click_pulse=0, `timer`==WINDOW_CYCLES-1 → report `count`, then enter HOLDOFF or IDLE.
- WAIT, click_pulse=0, otherwise → `timer`++.
- HOLDOFF: click_pulse is ignored and discarded. `timer` counts from 0; at `timer`==HOLDOFF_CYCLES-1 the FSM goes to IDLE.
- A report is registered: click_valid=1 for exactly one cycle and click_count=value. click_count holds its value until the next report.
- busy = (state != IDLE), registered.

## Timing
- Reset: state=IDLE; `count`=0; `timer`=0; click_valid=0; click_count=0; busy=0. Reset mid-sequence discards the sequence with no report. Reset dominates click_pulse on the same edge.
- Timeout latency: if the last click is sampled at edge E0, click_valid is high in the cycle after edge E_WINDOW_CYCLES.
- Saturation latency: the pulse that reaches MAX_CLICKS, sampled at E0, makes click_valid high in the cycle after E0.
- A pulse coincident with the timeout edge (`timer`==WINDOW_CYCLES-1) extends the sequence; no report is issued.
- With HOLDOFF_CYCLES=0: a pulse in the cycle where click_valid is high is sampled in IDLE and starts a new sequence.
- With HOLDOFF_CYCLES>0: busy stays high HOLDOFF_CYCLES cycles after click_valid. A pulse in the last holdoff cycle is dropped.
- click_pulse held high for N cycles counts as N clicks, saturating at MAX_CLICKS.
- The timer never wraps: it is reset on every accepted click and on every state change.

## Structure
- The shared package holds:
  - state encodings IDLE/WAIT/HOLDOFF as localparams;
  - the CW width function, so consumers can size click_count.
- One sub-module, `cycle_timer`. It is a loadable up-counter with clear, enable and terminal-compare (`timer`==limit-1) and is reused for both the window and the holdoff.
- The top is instantiated after the one-shot stage, with click_pulse driven by its signal_one_shot output.

## Test plan
(Bench parameters: WINDOW_CYCLES=8, MAX_CLICKS=3, HOLDOFF_CYCLES=0 unless stated.)
- Single click at cycle 10 → click_valid high at cycle 18 only, click_count=1; busy high cycles 11–18.
- Clicks at cycles 10 and 15 → one report at cycle 23, click_count=2; no strobe at 18.
- Clicks at 10, 12 and 14 → click_valid at cycle 15, click_count=3 (saturation, no wait for timeout). A new click at 15 opens a new sequence reported at 23 with count 1.
- Click at 10, second click exactly at cycle 17 (timeout edge) → sequence extended, report at 25 with count 2.
- HOLDOFF_CYCLES=4: saturate at cycle 15, pulses at 16 and 19 ignored, busy low from cycle 20. A pulse at 20 starts a new sequence with count 1.
- Reset asserted at cycle 13 mid-sequence → no click_valid ever, click_count=0, busy=0 at cycle 14. click_pulse held high cycles 30–34 → report of 3 at cycle 33.

Source files
------------

// File: rtl/multi_click_detector_pkg.sv
// Shared definitions for the multi-click detector: FSM state encodings and
// the click_count width helper for consumers sizing their ports.
package multi_click_detector_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_WAIT    = ST_WAIT,
    S_HOLDOFF = ST_HOLDOFF
  } state_e;

  function automatic int count_width(input int max_clicks);
    return $clog2(max_clicks + 1);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Up-counter with synchronous clear and enable; flags the cycle where the
// count equals limit-1. Shared by the click window and the report holdoff.
module cycle_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [TW-1:0] limit,
  output logic [TW-1:0] value,
  output logic          terminal
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= '0;
    end else if (enable) begin
      value <= value + TW'(1);
    end
  end

  assign terminal = (value == limit - TW'(1));

endmodule

// File: rtl/multi_click_detector.sv
// Groups one-shot press pulses into click sequences and emits one strobe per
// sequence carrying the click count (saturating at MAX_CLICKS).
module multi_click_detector
  import multi_click_detector_pkg::*;
#(
  parameter int WINDOW_CYCLES  = 12_500_000,
  parameter int MAX_CLICKS     = 3,
  parameter int HOLDOFF_CYCLES = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  click_pulse,
  output logic                                  click_valid,
  output logic [count_width(MAX_CLICKS)-1:0]    click_count,
  output logic                                  busy
);

  localparam int CW = count_width(MAX_CLICKS);
  localparam int TW = $clog2(max_of(WINDOW_CYCLES, HOLDOFF_CYCLES) + 1);

  state_e          state, next_state;
  logic [CW-1:0]   count, count_next;
  logic [CW:0]     count_inc;
  logic [TW-1:0]   timer, limit;
  logic            timer_clear, timer_en, terminal;
  logic            report;
  logic [CW-1:0]   report_value;

  assign limit     = (state == S_HOLDOFF) ? TW'(HOLDOFF_CYCLES) : TW'(WINDOW_CYCLES);
  assign count_inc = (CW+1)'(count) + (CW+1)'(1);

  cycle_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .enable   (timer_en),
    .limit    (limit),
    .value    (timer),
    .terminal (terminal)
  );

  always_comb begin
    next_state   = state;
    count_next   = count;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    report       = 1'b0;
    report_value = count;
    case (state)
      S_IDLE: begin
        if (click_pulse) begin
          count_next  = CW'(1);
          timer_clear = 1'b1;
          next_state  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A click always wins over the window expiring on the same edge.
        if (click_pulse) begin
          timer_clear = 1'b1;
          if (count_inc < (CW+1)'(MAX_CLICKS)) begin
            count_next = count_inc[CW-1:0];
          end else begin
            report       = 1'b1;
            report_value = CW'(MAX_CLICKS);
            next_state   = (HOLDOFF_CYCLES > 0) ? S_HOLDOFF : S_IDLE;
          end
        end else if (terminal) begin
          timer_clear = 1'b1;
          report      = 1'b1;
          next_state  = (HOLDOFF_CYCLES > 0) ? S_HOLDOFF : S_IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (terminal) begin
          timer_clear = 1'b1;
          next_state  = S_IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: begin
        timer_clear = 1'b1;
        next_state  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      count       <= '0;
      click_valid <= 1'b0;
      click_count <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= next_state;
      count       <= count_next;
      click_valid <= report;
      busy        <= (state != S_IDLE);
      if (report) begin
        click_count <= report_value;
      end
    end
  end

endmodule

// File: tb/tb_multi_click_detector.sv
// Bench for multi_click_detector: a vector table, directed corner sequences and
// random traffic, all checked against a timestamp-based behavioural model.
module tb_multi_click_detector;

  localparam int W  = 8;
  localparam int M  = 3;
  localparam int HA = 0;
  localparam int HB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       click = 1'b0;
  logic       click_h = 1'b0;
  logic       dv, dv_h, db, db_h;
  logic [1:0] dc, dc_h;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  multi_click_detector #(.WINDOW_CYCLES(W), .MAX_CLICKS(M), .HOLDOFF_CYCLES(HA)) dut (
    .clk(clk), .rst(rst), .click_pulse(click),
    .click_valid(dv), .click_count(dc), .busy(db)
  );

  multi_click_detector #(.WINDOW_CYCLES(W), .MAX_CLICKS(M), .HOLDOFF_CYCLES(HB)) dut_h (
    .clk(clk), .rst(rst), .click_pulse(click_h),
    .click_valid(dv_h), .click_count(dc_h), .busy(db_h)
  );

  // Model: a sequence is described by its open flag, click total, edge index
  // of the latest click and the last edge index on which pulses are discarded.
  typedef struct {
    bit open;
    int n;
    int last;
    int hold_end;
    bit nonidle_prev;
    bit valid;
    int cnt;
    bit busy;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, bit r, bit p, int k, int hold);
    mdl_t o = m;
    if (r) begin
      o.open = 0; o.n = 0; o.last = 0; o.hold_end = -1000;
      o.nonidle_prev = 0; o.valid = 0; o.cnt = 0; o.busy = 0;
      return o;
    end
    o.valid = 0;
    o.busy  = m.nonidle_prev;
    if (k <= m.hold_end) begin
      // pulse discarded during holdoff
    end else if (!m.open) begin
      if (p) begin o.open = 1; o.n = 1; o.last = k; end
    end else if (p) begin
      o.n = m.n + 1;
      if (o.n == M) begin
        o.valid = 1; o.cnt = M; o.open = 0; o.hold_end = k + hold;
      end else begin
        o.last = k;
      end
    end else if (k - m.last == W) begin
      o.valid = 1; o.cnt = m.n; o.open = 0; o.hold_end = k + hold;
    end
    o.nonidle_prev = o.open || (k < o.hold_end);
    return o;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic tick(input bit r, input bit p, input bit ph);
    @(negedge clk);
    rst = r; click = p; click_h = ph;
    @(posedge clk);
    #1;
    ma = mstep(ma, r, p, cyc, HA);
    mb = mstep(mb, r, ph, cyc, HB);
    chk("model_valid",   int'(dv),   int'(ma.valid));
    chk("model_count",   int'(dc),   ma.cnt);
    chk("model_busy",    int'(db),   int'(ma.busy));
    chk("model_valid_h", int'(dv_h), int'(mb.valid));
    chk("model_count_h", int'(dc_h), mb.cnt);
    chk("model_busy_h",  int'(db_h), int'(mb.busy));
    cyc++;
  endtask

  typedef struct {
    bit rst;
    bit click;
    bit exp_valid;
    int exp_count;
    bit exp_busy;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Reset, one click, then a full window of silence until the report.
    tbl[0] = '{1, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 0, 0, 0};
    for (int i = 2; i <= 8; i++) tbl[i] = '{0, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 1, 1, 1};
    tbl[10] = '{0, 0, 0, 1, 0};

    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].rst, tbl[i].click, 1'b0);
      chk("tbl_valid", int'(dv), int'(tbl[i].exp_valid));
      chk("tbl_count", int'(dc), tbl[i].exp_count);
      chk("tbl_busy",  int'(db), int'(tbl[i].exp_busy));
    end
    repeat (4) tick(0, 0, 0);

    // Double click: second click resets the window, one report of 2.
    for (int i = 0; i < 16; i++) begin
      tick(0, (i == 0 || i == 5), 0);
      if (i == 8)  chk("dbl_no_early", int'(dv), 0);
      if (i == 13) begin chk("dbl_valid", int'(dv), 1); chk("dbl_count", int'(dc), 2); end
    end

    // Saturation reports at once; a click right after opens a new sequence.
    for (int i = 0; i < 16; i++) begin
      tick(0, (i == 0 || i == 2 || i == 4 || i == 5), 0);
      if (i == 4)  begin chk("sat_valid", int'(dv), 1); chk("sat_count", int'(dc), 3); end
      if (i == 13) begin chk("resume_valid", int'(dv), 1); chk("resume_count", int'(dc), 1); end
    end

    // Click on the timeout edge extends the sequence.
    for (int i = 0; i < 18; i++) begin
      tick(0, (i == 0 || i == 8), 0);
      if (i == 8)  chk("ext_no_report", int'(dv), 0);
      if (i == 16) begin chk("ext_valid", int'(dv), 1); chk("ext_count", int'(dc), 2); end
    end

    // Holdoff instance: pulses during holdoff dropped, including the last cycle.
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, (i == 0 || i == 2 || i == 4 || i == 5 || i == 8 || i == 9));
      if (i == 4)  begin chk("ho_sat_valid", int'(dv_h), 1); chk("ho_sat_count", int'(dc_h), 3); end
      if (i == 8)  chk("ho_busy_last", int'(db_h), 1);
      if (i == 9)  chk("ho_busy_low", int'(db_h), 0);
      if (i == 17) begin chk("ho_new_valid", int'(dv_h), 1); chk("ho_new_count", int'(dc_h), 1); end
    end

    // Reset mid-sequence discards it; then a held pulse saturates.
    tick(0, 1, 1);
    tick(0, 0, 0);
    tick(0, 1, 1);
    tick(1, 1, 1);
    chk("rst_valid", int'(dv), 0);
    chk("rst_count", int'(dc), 0);
    chk("rst_busy",  int'(db), 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 1);
      if (i == 2) begin chk("held_valid", int'(dv), 1); chk("held_count", int'(dc), 3); end
    end
    repeat (20) tick(0, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
